// File: rtl/gpio_input_conditioner_if.sv
// Board-input conditioning bus: raw pins and flag clears in, conditioned levels,
// edge pulses and sticky change flags out.
interface gpio_input_conditioner_if #(
  parameter int N_CH = 1
);
  logic [N_CH-1:0] gpio_pin;
  logic [N_CH-1:0] gpio_clean;
  logic [N_CH-1:0] gpio_rise;
  logic [N_CH-1:0] gpio_fall;
  logic [N_CH-1:0] evt_flag;
  logic [N_CH-1:0] evt_clr;

  // Handshake: none. gpio_pin is asynchronous; evt_clr is level-sampled every clk
  // edge; all outputs are registered and valid every cycle after reset.
  modport master (
    output gpio_pin,
    output evt_clr,
    input  gpio_clean,
    input  gpio_rise,
    input  gpio_fall,
    input  evt_flag
  );

  modport slave (
    input  gpio_pin,
    input  evt_clr,
    output gpio_clean,
    output gpio_rise,
    output gpio_fall,
    output evt_flag
  );
endinterface

// File: rtl/gpio_input_conditioner.sv
// Per-channel synchroniser, debouncer, registered rise/fall pulses and a sticky
// change flag for raw board inputs feeding the system GPIO input port.
module gpio_input_conditioner #(
  parameter int   N_CH            = 1,
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 65536,
  parameter logic INIT_LEVEL      = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  gpio_input_conditioner_if.slave  bus
);
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q [N_CH];
  logic [CW-1:0]          cnt_q  [N_CH];
  logic [N_CH-1:0]        clean_q;
  logic [N_CH-1:0]        rise_q;
  logic [N_CH-1:0]        fall_q;
  logic [N_CH-1:0]        flag_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) begin
        sync_q[i] <= {SYNC_STAGES{INIT_LEVEL}};
        cnt_q[i]  <= '0;
      end
      clean_q <= {N_CH{INIT_LEVEL}};
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], bus.gpio_pin[i]};
        rise_q[i] <= 1'b0;
        fall_q[i] <= 1'b0;
        // Any cycle of agreement with the accepted level restarts the count.
        if (sync_q[i][SYNC_STAGES-1] == clean_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          cnt_q[i]   <= '0;
          clean_q[i] <= sync_q[i][SYNC_STAGES-1];
          rise_q[i]  <= sync_q[i][SYNC_STAGES-1];
          fall_q[i]  <= ~sync_q[i][SYNC_STAGES-1];
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // A pulse in the same cycle as a clear keeps the flag set so no event is lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      flag_q <= '0;
    end else begin
      flag_q <= rise_q | fall_q | (flag_q & ~bus.evt_clr);
    end
  end

  assign bus.gpio_clean = clean_q;
  assign bus.gpio_rise  = rise_q;
  assign bus.gpio_fall  = fall_q;
  assign bus.evt_flag   = flag_q;
endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed bench: a two-channel instance with a 4-cycle debounce driven from a vector
// table, plus mid-debounce reset and a 1-cycle-debounce pulse train on a second instance.
module tb_gpio_input_conditioner;
  logic clk;
  logic rst_a;
  logic rst_b;

  gpio_input_conditioner_if #(.N_CH(2)) bus_a ();
  gpio_input_conditioner_if #(.N_CH(1)) bus_b ();

  gpio_input_conditioner #(
    .N_CH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .INIT_LEVEL(1'b0)
  ) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  gpio_input_conditioner #(
    .N_CH(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .INIT_LEVEL(1'b0)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic       rst;
    logic [1:0] pin;
    logic [1:0] clr;
    int         n;
    logic [7:0] exp;   // {clean, rise, fall, flag}
  } vec_t;

  localparam int NV = 21;
  localparam int NB = 18;

  vec_t vecs [NV];
  int   pass_cnt;
  int   total_cnt;
  int   first_clean;
  int   first_rise;
  int   rises0;
  int   rises1;
  int   falls;
  logic pin_h [NB];
  logic ec    [NB];
  logic er    [NB];
  logic ef    [NB];
  logic efl   [NB];

  function automatic vec_t v(input logic r, input logic [1:0] p, input logic [1:0] c,
                             input int n, input logic [1:0] cl, input logic [1:0] ri,
                             input logic [1:0] fa, input logic [1:0] fl);
    vec_t t;
    t.rst = r;
    t.pin = p;
    t.clr = c;
    t.n   = n;
    t.exp = {cl, ri, fa, fl};
    return t;
  endfunction

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // driver
  task automatic tick_a(input logic r, input logic [1:0] p, input logic [1:0] c);
    rst_a          = r;
    bus_a.gpio_pin = p;
    bus_a.evt_clr  = c;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] obs_a();
    return {bus_a.gpio_clean, bus_a.gpio_rise, bus_a.gpio_fall, bus_a.evt_flag};
  endfunction

  initial begin
    pass_cnt       = 0;
    total_cnt      = 0;
    rst_a          = 1'b0;
    rst_b          = 1'b0;
    bus_a.gpio_pin = 2'b00;
    bus_a.evt_clr  = 2'b00;
    bus_b.gpio_pin = 1'b0;
    bus_b.evt_clr  = 1'b1;

    // reset with pins high, then accept after 6 edges
    vecs[0]  = v(1'b0, 2'b11, 2'b00, 3, 2'b00, 2'b00, 2'b00, 2'b00);
    vecs[1]  = v(1'b1, 2'b11, 2'b00, 5, 2'b00, 2'b00, 2'b00, 2'b00);
    vecs[2]  = v(1'b1, 2'b11, 2'b00, 1, 2'b11, 2'b11, 2'b00, 2'b00);
    vecs[3]  = v(1'b1, 2'b11, 2'b00, 1, 2'b11, 2'b00, 2'b00, 2'b11);
    // fall, clear coinciding with the pulse, then per-channel clears
    vecs[4]  = v(1'b1, 2'b00, 2'b00, 5, 2'b11, 2'b00, 2'b00, 2'b11);
    vecs[5]  = v(1'b1, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b11, 2'b11);
    vecs[6]  = v(1'b1, 2'b00, 2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b11);
    vecs[7]  = v(1'b1, 2'b00, 2'b01, 1, 2'b00, 2'b00, 2'b00, 2'b10);
    vecs[8]  = v(1'b1, 2'b00, 2'b10, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    vecs[9]  = v(1'b1, 2'b00, 2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    // ch0 high 3 cycles (rejected), ch1 high 4 cycles (accepted, then falls back)
    vecs[10] = v(1'b1, 2'b11, 2'b00, 3, 2'b00, 2'b00, 2'b00, 2'b00);
    vecs[11] = v(1'b1, 2'b10, 2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    vecs[12] = v(1'b1, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    vecs[13] = v(1'b1, 2'b00, 2'b00, 1, 2'b10, 2'b10, 2'b00, 2'b00);
    vecs[14] = v(1'b1, 2'b00, 2'b00, 3, 2'b10, 2'b00, 2'b00, 2'b10);
    vecs[15] = v(1'b1, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b10, 2'b10);
    vecs[16] = v(1'b1, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b10);
    vecs[17] = v(1'b1, 2'b00, 2'b10, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    // clean step on ch0 only
    vecs[18] = v(1'b1, 2'b01, 2'b00, 5, 2'b00, 2'b00, 2'b00, 2'b00);
    vecs[19] = v(1'b1, 2'b01, 2'b00, 1, 2'b01, 2'b01, 2'b00, 2'b00);
    vecs[20] = v(1'b1, 2'b01, 2'b00, 4, 2'b01, 2'b00, 2'b00, 2'b01);

    for (int r = 0; r < NV; r++) begin
      for (int k = 0; k < vecs[r].n; k++) begin
        tick_a(vecs[r].rst, vecs[r].pin, vecs[r].clr);
        check($sformatf("vec%0d.%0d", r, k), 32'(obs_a()), 32'(vecs[r].exp));
      end
    end

    // reset in the middle of a 0->1 debounce discards the partial count
    repeat (2) tick_a(1'b0, 2'b00, 2'b00);
    check("t5_reset_state", 32'(obs_a()), 32'h0);
    repeat (3) tick_a(1'b1, 2'b00, 2'b00);
    repeat (4) tick_a(1'b1, 2'b11, 2'b00);
    check("t5_cnt2_no_flip", 32'(obs_a()), 32'h0);
    tick_a(1'b0, 2'b11, 2'b00);
    check("t5_in_reset", 32'(obs_a()), 32'h0);
    first_clean = -1;
    first_rise  = -1;
    rises0      = 0;
    rises1      = 0;
    falls       = 0;
    for (int e = 1; e <= 12; e++) begin
      tick_a(1'b1, 2'b11, 2'b00);
      if (bus_a.gpio_clean == 2'b11 && first_clean < 0) first_clean = e;
      if (bus_a.gpio_rise != 2'b00 && first_rise < 0) first_rise = e;
      rises0 += int'(bus_a.gpio_rise[0]);
      rises1 += int'(bus_a.gpio_rise[1]);
      falls  += int'(|bus_a.gpio_fall);
    end
    check("t5_clean_edge", 32'(first_clean), 32'd6);
    check("t5_rise_edge", 32'(first_rise), 32'd6);
    check("t5_rise_count", {rises1[15:0], rises0[15:0]}, {16'd1, 16'd1});
    check("t5_no_fall", 32'(falls), 32'd0);
    check("t5_final", 32'(obs_a()), 32'hC3);

    // 1-cycle debounce: pin pulse every 3 cycles, clr held so the flag lasts one cycle
    check("t6_reset_state",
          32'({bus_b.gpio_clean, bus_b.gpio_rise, bus_b.gpio_fall, bus_b.evt_flag}), 32'h0);
    for (int c = 0; c < NB; c++) begin
      pin_h[c] = (c % 3 == 0);
      ec[c]    = (c >= 2) ? pin_h[c-2] : 1'b0;
      er[c]    = ec[c] & ~((c >= 1) ? ec[c-1] : 1'b0);
      ef[c]    = ~ec[c] & ((c >= 1) ? ec[c-1] : 1'b0);
      efl[c]   = (c >= 1) ? (er[c-1] | ef[c-1]) : 1'b0;
    end
    for (int c = 0; c < NB; c++) begin
      rst_b          = 1'b1;
      bus_b.gpio_pin = pin_h[c];
      @(posedge clk);
      #1;
      check($sformatf("t6_cyc%0d", c),
            32'({bus_b.gpio_clean, bus_b.gpio_rise, bus_b.gpio_fall, bus_b.evt_flag}),
            32'({ec[c], er[c], ef[c], efl[c]}));
    end

    // final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
